// File: rtl/bit_serial_adder.sv
// Bit-serial W-bit unsigned adder: one full-adder slice (two half adders plus a
// carry flop) consumes the operands LSB-first, one bit per clock, behind a start/done handshake.
//
// state | meaning
// IDLE  | waiting for start; SUM/COUT hold the last result
// SHIFT | one operand bit pair added per cycle, W cycles in total
// DONE  | one-cycle done pulse; SUM/COUT already valid
module bit_serial_adder #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] SUM,
  output logic         COUT
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (W > 1) ? W - 1 : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    ra, rb;
  logic [RW-1:0]   racc;
  logic [W-1:0]    racc_nxt;
  logic            carry;
  logic [CW-1:0]   count;
  logic            s1, c1, sbit, c2, nxt_carry;

  function automatic logic [1:0] half_add(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  always_comb begin
    {c1, s1}   = half_add(ra[0], rb[0]);
    {c2, sbit} = half_add(s1, carry);
    nxt_carry  = c1 | c2;
  end

  // racc keeps only the W-1 partial bits already produced; the slice output
  // completes the word, so the final sum is available on the last SHIFT edge.
  generate
    if (W == 1) begin : g_w1
      assign racc_nxt = sbit;
    end else begin : g_wn
      assign racc_nxt = {sbit, racc};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (count == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      racc  <= '0;
      carry <= 1'b0;
      count <= '0;
      SUM   <= '0;
      COUT  <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            ra    <= A;
            rb    <= B;
            carry <= 1'b0;
            count <= '0;
          end
        end
        SHIFT: begin
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          racc  <= racc_nxt[W-1 -: RW];
          carry <= nxt_carry;
          count <= count + 1'b1;
          if (count == LAST) begin
            SUM  <= racc_nxt;
            COUT <= nxt_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
